// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, each with a 1-deep result slot.
// Optional grant/conflict counters when ALU_SHARE_PERF_CNT_EN is defined.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int CTL_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [CTL_WIDTH-1:0]  req0_ctl,
  input  logic [DATA_WIDTH-1:0] req0_da,
  input  logic [DATA_WIDTH-1:0] req0_db,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_dc,
  output logic                  rsp0_zero,
  output logic                  rsp0_ovf,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [CTL_WIDTH-1:0]  req1_ctl,
  input  logic [DATA_WIDTH-1:0] req1_da,
  input  logic [DATA_WIDTH-1:0] req1_db,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_dc,
  output logic                  rsp1_zero,
  output logic                  rsp1_ovf,
  output logic [CTL_WIDTH-1:0]  alu_ctl,
  output logic [DATA_WIDTH-1:0] alu_da,
  output logic [DATA_WIDTH-1:0] alu_db,
  input  logic [DATA_WIDTH-1:0] alu_dc,
  input  logic                  alu_zero,
  input  logic                  alu_ovf
`ifdef ALU_SHARE_PERF_CNT_EN
  ,
  output logic [31:0]           perf_grant0,
  output logic [31:0]           perf_grant1,
  output logic [31:0]           perf_conflict
`endif
);

  logic                  elig0, elig1;
  logic                  gnt0, gnt1;
  logic                  last_q, last_d;
  logic                  v0_q, v0_d, v1_q, v1_d;
  logic [DATA_WIDTH-1:0] dc0_q, dc0_d, dc1_q, dc1_d;
  logic                  z0_q, z0_d, z1_q, z1_d;
  logic                  o0_q, o0_d, o1_q, o1_d;

  // last_q = 1 means port 1 was granted most recently
  always_comb begin
    elig0  = req0_valid && (!v0_q || rsp0_ready);
    elig1  = req1_valid && (!v1_q || rsp1_ready);
    gnt0   = elig0 && (!elig1 || last_q);
    gnt1   = elig1 && (!elig0 || !last_q);
    last_d = last_q;
    if (gnt0) last_d = 1'b0;
    else if (gnt1) last_d = 1'b1;
  end

  always_comb begin
    alu_ctl = '0;
    alu_da  = '0;
    alu_db  = '0;
    unique case (1'b1)
      gnt0: begin
        alu_ctl = req0_ctl;
        alu_da  = req0_da;
        alu_db  = req0_db;
      end
      gnt1: begin
        alu_ctl = req1_ctl;
        alu_da  = req1_da;
        alu_db  = req1_db;
      end
      default: ;
    endcase
  end

  always_comb begin
    v0_d  = v0_q;
    dc0_d = dc0_q;
    z0_d  = z0_q;
    o0_d  = o0_q;
    if (gnt0) begin
      v0_d  = 1'b1;
      dc0_d = alu_dc;
      z0_d  = alu_zero;
      o0_d  = alu_ovf;
    end else if (rsp0_ready) begin
      v0_d  = 1'b0;
    end
  end

  always_comb begin
    v1_d  = v1_q;
    dc1_d = dc1_q;
    z1_d  = z1_q;
    o1_d  = o1_q;
    if (gnt1) begin
      v1_d  = 1'b1;
      dc1_d = alu_dc;
      z1_d  = alu_zero;
      o1_d  = alu_ovf;
    end else if (rsp1_ready) begin
      v1_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
      v0_q   <= 1'b0;
      dc0_q  <= '0;
      z0_q   <= 1'b0;
      o0_q   <= 1'b0;
      v1_q   <= 1'b0;
      dc1_q  <= '0;
      z1_q   <= 1'b0;
      o1_q   <= 1'b0;
    end else begin
      last_q <= last_d;
      v0_q   <= v0_d;
      dc0_q  <= dc0_d;
      z0_q   <= z0_d;
      o0_q   <= o0_d;
      v1_q   <= v1_d;
      dc1_q  <= dc1_d;
      z1_q   <= z1_d;
      o1_q   <= o1_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = v0_q;
  assign rsp0_dc    = dc0_q;
  assign rsp0_zero  = z0_q;
  assign rsp0_ovf   = o0_q;
  assign rsp1_valid = v1_q;
  assign rsp1_dc    = dc1_q;
  assign rsp1_zero  = z1_q;
  assign rsp1_ovf   = o1_q;

`ifdef ALU_SHARE_PERF_CNT_EN
  logic [31:0] pg0_q, pg0_d, pg1_q, pg1_d, pc_q, pc_d;

  // with both valid, at most one can be granted, so every such cycle is a conflict
  always_comb begin
    pg0_d = pg0_q + {31'd0, gnt0};
    pg1_d = pg1_q + {31'd0, gnt1};
    pc_d  = pc_q + {31'd0, req0_valid && req1_valid};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pg0_q <= '0;
      pg1_q <= '0;
      pc_q  <= '0;
    end else begin
      pg0_q <= pg0_d;
      pg1_q <= pg1_d;
      pc_q  <= pc_d;
    end
  end

  assign perf_grant0   = pg0_q;
  assign perf_grant1   = pg1_q;
  assign perf_conflict = pc_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small stand-in ALU (0x00 ADD, 0x01 SUB).
// Drives inputs on the falling edge, samples #1 after edges.
module tb_alu_share_arbiter;

  localparam int DW = 64;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [CW-1:0] req0_ctl;
  logic [DW-1:0] req0_da, req0_db, rsp0_dc;
  logic          rsp0_zero, rsp0_ovf;
  logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [CW-1:0] req1_ctl;
  logic [DW-1:0] req1_da, req1_db, rsp1_dc;
  logic          rsp1_zero, rsp1_ovf;
  logic [CW-1:0] alu_ctl;
  logic [DW-1:0] alu_da, alu_db, alu_dc;
  logic          alu_zero, alu_ovf;
`ifdef ALU_SHARE_PERF_CNT_EN
  logic [31:0]   perf_grant0, perf_grant1, perf_conflict;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(DW), .CTL_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
    .req0_da(req0_da), .req0_db(req0_db),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_dc(rsp0_dc),
    .rsp0_zero(rsp0_zero), .rsp0_ovf(rsp0_ovf),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
    .req1_da(req1_da), .req1_db(req1_db),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_dc(rsp1_dc),
    .rsp1_zero(rsp1_zero), .rsp1_ovf(rsp1_ovf),
    .alu_ctl(alu_ctl), .alu_da(alu_da), .alu_db(alu_db),
    .alu_dc(alu_dc), .alu_zero(alu_zero), .alu_ovf(alu_ovf)
`ifdef ALU_SHARE_PERF_CNT_EN
    ,
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
    .perf_conflict(perf_conflict)
`endif
  );

  // stand-in shared ALU
  always_comb begin
    alu_dc  = '0;
    alu_ovf = 1'b0;
    case (alu_ctl)
      5'h00: begin
        alu_dc  = alu_da + alu_db;
        alu_ovf = (alu_da[DW-1] == alu_db[DW-1]) && (alu_dc[DW-1] != alu_da[DW-1]);
      end
      5'h01: begin
        alu_dc  = alu_da - alu_db;
        alu_ovf = (alu_da[DW-1] != alu_db[DW-1]) && (alu_dc[DW-1] != alu_da[DW-1]);
      end
      default: ;
    endcase
    alu_zero = (alu_dc == '0);
  end

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 0; req0_ctl = 0; req0_da = 0; req0_db = 0; rsp0_ready = 1;
    req1_valid = 0; req1_ctl = 0; req1_da = 0; req1_db = 0; rsp1_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      fails++; $display("FAIL reset_valid got=%b exp=00", {rsp0_valid, rsp1_valid});
    end
    tests++;
    if ({rsp0_dc, rsp1_dc, rsp0_zero, rsp0_ovf, rsp1_zero, rsp1_ovf} !== '0) begin
      fails++; $display("FAIL reset_data dc0=%h dc1=%h exp=0", rsp0_dc, rsp1_dc);
    end
    tests++;
    if ({alu_ctl, alu_da, alu_db} !== '0) begin
      fails++; $display("FAIL reset_alu ctl=%h da=%h db=%h exp=0", alu_ctl, alu_da, alu_db);
    end
  endtask

  task automatic test_single_op();
    @(negedge clk);
    req0_valid = 1; req0_ctl = 5'h00; req0_da = 5; req0_db = 7; rsp0_ready = 1;
    #1;
    tests++;
    if (req0_ready !== 1'b1 || alu_da !== 64'd5 || alu_db !== 64'd7) begin
      fails++; $display("FAIL single_grant ready=%b da=%0d db=%0d exp=1/5/7", req0_ready, alu_da, alu_db);
    end
    @(posedge clk); #1;
    tests++;
    if (rsp0_valid !== 1'b1 || rsp0_dc !== 64'd12 || rsp0_zero !== 1'b0 || rsp0_ovf !== 1'b0) begin
      fails++; $display("FAIL single_rsp v=%b dc=%0d z=%b o=%b exp=1/12/0/0", rsp0_valid, rsp0_dc, rsp0_zero, rsp0_ovf);
    end
    @(negedge clk);
    req0_valid = 0;
    @(posedge clk); #1;
    tests++;
    if (rsp0_valid !== 1'b0) begin
      fails++; $display("FAIL single_drain v=%b exp=0", rsp0_valid);
    end
  endtask

  task automatic test_contention();
    logic [3:0]  exp_g1;
    logic [63:0] exp_dc [4];
    int n0, n1;
    exp_g1 = 4'b1010;
    exp_dc[0] = 64'd11; exp_dc[1] = 64'd102;
    exp_dc[2] = 64'd12; exp_dc[3] = 64'd103;
    do_reset();
    n0 = 0; n1 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req0_valid = 1; req0_ctl = 0; req0_da = 64'(10 + n0); req0_db = 1;
      req1_valid = 1; req1_ctl = 0; req1_da = 64'(100 + n1); req1_db = 2;
      #1;
      tests++;
      if ({req1_ready, req0_ready} !== (exp_g1[k] ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL contend_grant[%0d] r1r0=%b%b exp_g1=%b", k, req1_ready, req0_ready, exp_g1[k]);
      end
      if (req0_ready) n0++;
      if (req1_ready) n1++;
      @(posedge clk); #1;
      tests++;
      if (exp_g1[k] ? (rsp1_valid !== 1'b1 || rsp1_dc !== exp_dc[k] || rsp0_valid !== 1'b0)
                    : (rsp0_valid !== 1'b1 || rsp0_dc !== exp_dc[k] || rsp1_valid !== 1'b0)) begin
        fails++; $display("FAIL contend_rsp[%0d] v0=%b dc0=%0d v1=%b dc1=%0d exp_dc=%0d", k, rsp0_valid, rsp0_dc, rsp1_valid, rsp1_dc, exp_dc[k]);
      end
    end
`ifdef ALU_SHARE_PERF_CNT_EN
    tests++;
    if (perf_grant0 !== 32'd2 || perf_grant1 !== 32'd2 || perf_conflict !== 32'd4) begin
      fails++; $display("FAIL perf_cnt g0=%0d g1=%0d c=%0d exp=2/2/4", perf_grant0, perf_grant1, perf_conflict);
    end
`endif
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 1;
    req0_valid = 1; req0_ctl = 0; req0_da = 1; req0_db = 1;
    req1_valid = 1; req1_ctl = 0; req1_da = 10; req1_db = 10;
    #1;
    tests++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      fails++; $display("FAIL bp_first r1r0=%b%b exp=01", req1_ready, req0_ready);
    end
    @(negedge clk);
    req0_da = 2; req0_db = 2;
    #1;
    tests++;
    if ({req1_ready, req0_ready} !== 2'b10 || alu_da !== 64'd10) begin
      fails++; $display("FAIL bp_block r1r0=%b%b alu_da=%0d exp=10/10", req1_ready, req0_ready, alu_da);
    end
    @(posedge clk); #1;
    tests++;
    if (rsp0_dc !== 64'd2 || rsp0_valid !== 1'b1 || rsp1_dc !== 64'd20) begin
      fails++; $display("FAIL bp_hold1 dc0=%0d v0=%b dc1=%0d exp=2/1/20", rsp0_dc, rsp0_valid, rsp1_dc);
    end
    @(negedge clk);
    req1_da = 3; req1_db = 4;
    #1;
    tests++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      fails++; $display("FAIL bp_other r1r0=%b%b exp=10", req1_ready, req0_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (rsp0_dc !== 64'd2 || rsp1_dc !== 64'd7) begin
      fails++; $display("FAIL bp_hold2 dc0=%0d dc1=%0d exp=2/7", rsp0_dc, rsp1_dc);
    end
    @(negedge clk);
    req1_valid = 0; rsp0_ready = 1;
    #1;
    tests++;
    if (req0_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release r0=%b exp=1", req0_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (rsp0_valid !== 1'b1 || rsp0_dc !== 64'd4) begin
      fails++; $display("FAIL bp_second v0=%b dc0=%0d exp=1/4", rsp0_valid, rsp0_dc);
    end
  endtask

  task automatic test_drain_refill();
    @(negedge clk);
    rsp0_ready = 1; req0_valid = 1; req0_ctl = 5'h01; req0_da = 3; req0_db = 3;
    #1;
    tests++;
    if (req0_ready !== 1'b1) begin
      fails++; $display("FAIL refill_grant r0=%b exp=1", req0_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (rsp0_valid !== 1'b1 || rsp0_dc !== 64'd0 || rsp0_zero !== 1'b1) begin
      fails++; $display("FAIL refill_rsp v0=%b dc0=%0d z=%b exp=1/0/1", rsp0_valid, rsp0_dc, rsp0_zero);
    end
  endtask

  task automatic test_both_full();
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;
    req0_ctl = 0; req0_da = 8; req0_db = 8;
    req1_valid = 1; req1_ctl = 0; req1_da = 1; req1_db = 2;
    @(posedge clk); #1;
    tests++;
    if (rsp1_valid !== 1'b1 || rsp1_dc !== 64'd3) begin
      fails++; $display("FAIL full_fill v1=%b dc1=%0d exp=1/3", rsp1_valid, rsp1_dc);
    end
    @(negedge clk); #1;
    tests++;
    if ({req1_ready, req0_ready} !== 2'b00 || {alu_ctl, alu_da, alu_db} !== '0) begin
      fails++; $display("FAIL full_nogrant r1r0=%b%b ctl=%h da=%h db=%h exp=00/0", req1_ready, req0_ready, alu_ctl, alu_da, alu_db);
    end
    @(posedge clk); #1;
    tests++;
    if (rsp0_dc !== 64'd0 || rsp0_zero !== 1'b1 || rsp1_dc !== 64'd3 || {rsp0_valid, rsp1_valid} !== 2'b11) begin
      fails++; $display("FAIL full_hold dc0=%0d z0=%b dc1=%0d v=%b%b exp=0/1/3/11", rsp0_dc, rsp0_zero, rsp1_dc, rsp0_valid, rsp1_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00 || rsp1_dc !== '0) begin
      fails++; $display("FAIL async_rst v=%b%b dc1=%0d exp=00/0", rsp0_valid, rsp1_valid, rsp1_dc);
    end
    @(negedge clk);
    rst = 1'b0;
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_ctl = 0; req0_da = 4; req0_db = 4;
    req1_valid = 1; req1_ctl = 0; req1_da = 5; req1_db = 5;
    #1;
    tests++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      fails++; $display("FAIL post_rst_grant r1r0=%b%b exp=01", req1_ready, req0_ready);
    end
`ifdef ALU_SHARE_PERF_CNT_EN
    tests++;
    if ({perf_grant0, perf_grant1, perf_conflict} !== '0) begin
      fails++; $display("FAIL post_rst_perf g0=%0d g1=%0d c=%0d exp=0", perf_grant0, perf_grant1, perf_conflict);
    end
`endif
    @(posedge clk); #1;
    tests++;
    if (rsp0_valid !== 1'b1 || rsp0_dc !== 64'd8 || rsp1_valid !== 1'b0) begin
      fails++; $display("FAIL post_rst_rsp v0=%b dc0=%0d v1=%b exp=1/8/0", rsp0_valid, rsp0_dc, rsp1_valid);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_overflow();
    @(negedge clk);
    req1_valid = 1; req1_ctl = 5'h00;
    req1_da = 64'h7FFF_FFFF_FFFF_FFFF; req1_db = 64'd1; rsp1_ready = 1;
    @(posedge clk); #1;
    tests++;
    if (rsp1_valid !== 1'b1 || rsp1_ovf !== 1'b1 || rsp1_dc !== 64'h8000_0000_0000_0000 || rsp1_zero !== 1'b0) begin
      fails++; $display("FAIL ovf v1=%b o=%b dc1=%h z=%b exp=1/1/8000000000000000/0", rsp1_valid, rsp1_ovf, rsp1_dc, rsp1_zero);
    end
    @(negedge clk);
    req1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_drain_refill();
    test_both_full();
    test_reset_mid();
    test_overflow();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
